operand_fetch: RTL and testbench

- Read-side counterpart of the write-back stage: owns the architectural register file, accepts the WB write port (mxrb_out path), and reads operands for the next instruction.
- Tracks pending destination writes and pending flag writes in a scoreboard. Stalls decode on hazards and forwards same-cycle WB data.
- Evaluates branch conditions against the WB flag outputs (rf_O/rf_S/rf_C/rf_Z).
- Sits between decode and the ALU stage; presents registered operands one cycle after acceptance.

---
 rtl/operand_fetch_pkg.sv | 50 +++++
 rtl/operand_fetch_regfile_2r1w.sv | 59 +++++
 rtl/operand_fetch.sv | 137 +++++++++++++
 tb/tb_operand_fetch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared constants for the operand-fetch stage: sizing defaults, R0 index,
// branch condition codes and the condition evaluator.
package operand_fetch_pkg;

  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int DW   = 32;

  localparam logic [AW-1:0] R0_IDX = 4'd0;

  // Condition codes evaluated against the WB flag outputs.
  localparam logic [3:0] COND_AL = 4'd0;   // always
  localparam logic [3:0] COND_EQ = 4'd1;   // Z
  localparam logic [3:0] COND_NE = 4'd2;   // !Z
  localparam logic [3:0] COND_MI = 4'd3;   // S
  localparam logic [3:0] COND_PL = 4'd4;   // !S
  localparam logic [3:0] COND_CS = 4'd5;   // C
  localparam logic [3:0] COND_CC = 4'd6;   // !C
  localparam logic [3:0] COND_VS = 4'd7;   // O
  localparam logic [3:0] COND_VC = 4'd8;   // !O
  localparam logic [3:0] COND_LT = 4'd9;   // S != O
  localparam logic [3:0] COND_GE = 4'd10;  // S == O
  localparam logic [3:0] COND_LE = 4'd11;  // Z | (S != O)
  localparam logic [3:0] COND_GT = 4'd12;  // !Z & (S == O)

  // Codes 13-15 are reserved and evaluate to "never".
  function automatic logic eval_cond(input logic [3:0] cond,
                                     input logic o, input logic s,
                                     input logic c, input logic z);
    logic res;
    case (cond)
      COND_AL: res = 1'b1;
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_MI: res = s;
      COND_PL: res = ~s;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_VS: res = o;
      COND_VC: res = ~o;
      COND_LT: res = s ^ o;
      COND_GE: res = ~(s ^ o);
      COND_LE: res = z | (s ^ o);
      COND_GT: res = ~z & ~(s ^ o);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/operand_fetch_regfile_2r1w.sv
// Architectural register file: two combinational read ports with WB bypass,
// one synchronous write port. R0 always reads as zero and is never stored.
module regfile_2r1w
  import operand_fetch_pkg::*;
#(
  parameter int P_NREG = NREG,
  parameter int P_AW   = AW,
  parameter int P_DW   = DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [P_AW-1:0]   waddr,
  input  logic [P_DW-1:0]   wdata,
  input  logic [P_AW-1:0]   ra,
  input  logic [P_AW-1:0]   rb,
  output logic [P_DW-1:0]   rdata_a,
  output logic [P_DW-1:0]   rdata_b
);

  logic [P_DW-1:0] regs_r [P_NREG];
  logic            wr_en_s;

  assign wr_en_s = we && (waddr != {P_AW{1'b0}});

  // Storage update: clear on reset, otherwise write the WB result (never R0).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < P_NREG; i++) begin
        regs_r[i] <= {P_DW{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[waddr] <= wdata;
    end else begin
      regs_r[waddr] <= regs_r[waddr];
    end
  end

  // Read ports: R0 is hard zero, a same-cycle WB write to the address wins.
  always_comb begin
    rdata_a = {P_DW{1'b0}};
    rdata_b = {P_DW{1'b0}};
    if (ra == {P_AW{1'b0}}) begin
      rdata_a = {P_DW{1'b0}};
    end else if (we && (waddr == ra)) begin
      rdata_a = wdata;
    end else begin
      rdata_a = regs_r[ra];
    end
    if (rb == {P_AW{1'b0}}) begin
      rdata_b = {P_DW{1'b0}};
    end else if (we && (waddr == rb)) begin
      rdata_b = wdata;
    end else begin
      rdata_b = regs_r[rb];
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register file read, destination/flag scoreboard,
// hazard stall toward decode, and branch condition evaluation.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic          id_valid,
  input  logic [AW-1:0] id_ra,
  input  logic [AW-1:0] id_rb,
  input  logic          id_use_ra,
  input  logic          id_use_rb,
  input  logic [AW-1:0] id_rd,
  input  logic          id_we_rd,
  input  logic          id_sets_flags,
  input  logic [3:0]    id_cond,
  input  logic          id_use_flags,
  output logic          id_stall,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          wb_flags_we,
  input  logic          rf_O,
  input  logic          rf_S,
  input  logic          rf_C,
  input  logic          rf_Z,
  output logic          of_valid,
  output logic [DW-1:0] of_a,
  output logic [DW-1:0] of_b,
  output logic [AW-1:0] of_rd,
  output logic          of_we_rd,
  output logic          of_cond_true
);

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_nxt_s;
  logic [NREG-1:0] busy_eff_s;
  logic [NREG-1:0] wb_clr_s;
  logic [NREG-1:0] id_set_s;
  logic            flags_busy_r;
  logic            flags_busy_nxt_s;
  logic            flags_busy_eff_s;
  logic            stall_s;
  logic            accept_s;
  logic            cond_s;
  logic [DW-1:0]   rd_a_s;
  logic [DW-1:0]   rd_b_s;

  regfile_2r1w #(
    .P_NREG (NREG),
    .P_AW   (AW),
    .P_DW   (DW)
  ) u_regfile (
    .clk     (CLK),
    .reset   (RESET),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .ra      (id_ra),
    .rb      (id_rb),
    .rdata_a (rd_a_s),
    .rdata_b (rd_b_s)
  );

  // Hazard detection: busy bits released by this cycle's WB no longer block.
  always_comb begin
    wb_clr_s = {NREG{1'b0}};
    if (wb_we) begin
      wb_clr_s[wb_addr] = 1'b1;
    end else begin
      wb_clr_s = {NREG{1'b0}};
    end
    busy_eff_s       = busy_r & ~wb_clr_s;
    busy_eff_s[0]    = 1'b0;
    flags_busy_eff_s = flags_busy_r && !wb_flags_we;
    stall_s = id_valid && ((id_use_ra    && busy_eff_s[id_ra]) ||
                           (id_use_rb    && busy_eff_s[id_rb]) ||
                           (id_we_rd     && busy_eff_s[id_rd]) ||
                           (id_use_flags && flags_busy_eff_s));
    accept_s = id_valid && !stall_s;
    cond_s   = id_use_flags ? eval_cond(id_cond, rf_O, rf_S, rf_C, rf_Z) : 1'b1;
  end

  assign id_stall = stall_s;

  // Scoreboard next state: WB clears, a newly accepted writer sets (set wins).
  always_comb begin
    id_set_s = {NREG{1'b0}};
    if (accept_s && id_we_rd && (id_rd != R0_IDX)) begin
      id_set_s[id_rd] = 1'b1;
    end else begin
      id_set_s = {NREG{1'b0}};
    end
    busy_nxt_s    = (busy_r & ~wb_clr_s) | id_set_s;
    busy_nxt_s[0] = 1'b0;
    if (accept_s && id_sets_flags) begin
      flags_busy_nxt_s = 1'b1;
    end else if (wb_flags_we) begin
      flags_busy_nxt_s = 1'b0;
    end else begin
      flags_busy_nxt_s = flags_busy_r;
    end
  end

  // Scoreboard registers; reset discards every pending write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy_r       <= {NREG{1'b0}};
      flags_busy_r <= 1'b0;
    end else begin
      busy_r       <= busy_nxt_s;
      flags_busy_r <= flags_busy_nxt_s;
    end
  end

  // Output register toward the ALU stage; payload holds when nothing is accepted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      of_valid     <= 1'b0;
      of_a         <= {DW{1'b0}};
      of_b         <= {DW{1'b0}};
      of_rd        <= {AW{1'b0}};
      of_we_rd     <= 1'b0;
      of_cond_true <= 1'b0;
    end else if (accept_s) begin
      of_valid     <= 1'b1;
      of_a         <= id_use_ra ? rd_a_s : {DW{1'b0}};
      of_b         <= id_use_rb ? rd_b_s : {DW{1'b0}};
      of_rd        <= id_rd;
      of_we_rd     <= id_we_rd;
      of_cond_true <= cond_s;
    end else begin
      of_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: condition-code table plus hazard,
// bypass, R0 and reset sequences.
module tb_operand_fetch;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        id_valid, id_use_ra, id_use_rb, id_we_rd, id_sets_flags, id_use_flags;
  logic [3:0]  id_ra, id_rb, id_rd, id_cond;
  logic        id_stall;
  logic        wb_we, wb_flags_we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rf_O, rf_S, rf_C, rf_Z;
  logic        of_valid, of_we_rd, of_cond_true;
  logic [31:0] of_a, of_b;
  logic [3:0]  of_rd;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] cond;
    logic       use_flags;
    logic       o, s, c, z;
    logic       exp;
  } cond_vec_t;

  cond_vec_t vecs [18];

  operand_fetch dut (
    .CLK(CLK), .RESET(RESET),
    .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
    .id_rd(id_rd), .id_we_rd(id_we_rd), .id_sets_flags(id_sets_flags),
    .id_cond(id_cond), .id_use_flags(id_use_flags), .id_stall(id_stall),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_flags_we(wb_flags_we),
    .rf_O(rf_O), .rf_S(rf_S), .rf_C(rf_C), .rf_Z(rf_Z),
    .of_valid(of_valid), .of_a(of_a), .of_b(of_b), .of_rd(of_rd),
    .of_we_rd(of_we_rd), .of_cond_true(of_cond_true)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle;
    id_valid = 1'b0; id_use_ra = 1'b0; id_use_rb = 1'b0; id_we_rd = 1'b0;
    id_sets_flags = 1'b0; id_use_flags = 1'b0;
    id_ra = 4'd0; id_rb = 4'd0; id_rd = 4'd0; id_cond = 4'd0;
    wb_we = 1'b0; wb_flags_we = 1'b0; wb_addr = 4'd0; wb_data = 32'd0;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{4'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{4'd4,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{4'd6,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{4'd8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'd9,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{4'd9,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{4'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{4'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{4'd13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    idle();
    rf_O = 1'b0; rf_S = 1'b0; rf_C = 1'b0; rf_Z = 1'b0;
    RESET = 1'b1;
    step(); step();
    RESET = 1'b0;
    chk("rst_of_valid", {31'd0, of_valid}, 32'd0);
    chk("rst_of_a", of_a, 32'd0);
    chk("rst_of_b", of_b, 32'd0);
    chk("rst_of_rd", {28'd0, of_rd}, 32'd0);
    chk("rst_of_we_rd", {31'd0, of_we_rd}, 32'd0);
    chk("rst_of_cond", {31'd0, of_cond_true}, 32'd0);

    // Read R3 after reset: no stall, reads zero.
    id_valid = 1'b1; id_use_ra = 1'b1; id_ra = 4'd3;
    #1 chk("r3_stall", {31'd0, id_stall}, 32'd0);
    step(); idle();
    chk("r3_valid", {31'd0, of_valid}, 32'd1);
    chk("r3_a", of_a, 32'd0);
    step();
    chk("idle_valid", {31'd0, of_valid}, 32'd0);

    // Condition-code table; flags are not pending here.
    for (int i = 0; i < 18; i++) begin
      id_valid = 1'b1; id_use_flags = vecs[i].use_flags; id_cond = vecs[i].cond;
      rf_O = vecs[i].o; rf_S = vecs[i].s; rf_C = vecs[i].c; rf_Z = vecs[i].z;
      #1 chk($sformatf("cond%0d_stall", i), {31'd0, id_stall}, 32'd0);
      step();
      chk($sformatf("cond%0d_result", i), {31'd0, of_cond_true}, {31'd0, vecs[i].exp});
    end
    idle();
    rf_O = 1'b0; rf_S = 1'b0; rf_C = 1'b0; rf_Z = 1'b0;

    // Writer to R5, then a reader waits for WB and takes the bypassed value.
    id_valid = 1'b1; id_we_rd = 1'b1; id_rd = 4'd5;
    step(); idle();
    chk("w5_rd", {28'd0, of_rd}, 32'd5);
    chk("w5_we_rd", {31'd0, of_we_rd}, 32'd1);
    id_valid = 1'b1; id_use_ra = 1'b1; id_ra = 4'd5;
    id_use_rb = 1'b0; id_rb = 4'd3;
    #1 chk("r5_stall0", {31'd0, id_stall}, 32'd1);
    step();
    chk("r5_stalled_valid", {31'd0, of_valid}, 32'd0);
    chk("r5_stall1", {31'd0, id_stall}, 32'd1);
    step();
    wb_we = 1'b1; wb_addr = 4'd5; wb_data = 32'hDEADBEEF;
    #1 chk("r5_stall_wb", {31'd0, id_stall}, 32'd0);
    step(); idle();
    chk("r5_valid", {31'd0, of_valid}, 32'd1);
    chk("r5_a", of_a, 32'hDEADBEEF);
    chk("r5_b_unused", of_b, 32'd0);

    // R5 now from storage, read on port B.
    id_valid = 1'b1; id_use_rb = 1'b1; id_rb = 4'd5;
    #1 chk("r5b_stall", {31'd0, id_stall}, 32'd0);
    step(); idle();
    chk("r5b_b", of_b, 32'hDEADBEEF);

    // Same-cycle WB clear and new writer set on R2: set wins.
    id_valid = 1'b1; id_we_rd = 1'b1; id_rd = 4'd2;
    step(); idle();
    wb_we = 1'b1; wb_addr = 4'd2; wb_data = 32'h1234;
    id_valid = 1'b1; id_we_rd = 1'b1; id_rd = 4'd2;
    #1 chk("r2_waw_stall", {31'd0, id_stall}, 32'd0);
    step(); idle();
    id_valid = 1'b1; id_use_ra = 1'b1; id_ra = 4'd2;
    #1 chk("r2_still_busy", {31'd0, id_stall}, 32'd1);
    step();
    wb_we = 1'b1; wb_addr = 4'd2; wb_data = 32'h5678;
    #1 chk("r2_release", {31'd0, id_stall}, 32'd0);
    step(); idle();
    chk("r2_a", of_a, 32'h5678);

    // Pending flag writer blocks a branch until WB updates flags (Z=1).
    id_valid = 1'b1; id_sets_flags = 1'b1;
    step(); idle();
    id_valid = 1'b1; id_use_flags = 1'b1; id_cond = 4'd1; rf_Z = 1'b1;
    #1 chk("fl_stall", {31'd0, id_stall}, 32'd1);
    step();
    chk("fl_stalled_valid", {31'd0, of_valid}, 32'd0);
    wb_flags_we = 1'b1;
    #1 chk("fl_release", {31'd0, id_stall}, 32'd0);
    step(); idle();
    chk("fl_z1", {31'd0, of_cond_true}, 32'd1);
    // Same again with Z=0.
    id_valid = 1'b1; id_sets_flags = 1'b1;
    step(); idle();
    id_valid = 1'b1; id_use_flags = 1'b1; id_cond = 4'd1; rf_Z = 1'b0;
    #1 chk("fl2_stall", {31'd0, id_stall}, 32'd1);
    wb_flags_we = 1'b1;
    step(); idle();
    chk("fl_z0", {31'd0, of_cond_true}, 32'd0);

    // WB to R0 is ignored, including the same-cycle bypass.
    wb_we = 1'b1; wb_addr = 4'd0; wb_data = 32'hFFFFFFFF;
    id_valid = 1'b1; id_use_ra = 1'b1; id_ra = 4'd0;
    step(); idle();
    chk("r0_bypass", of_a, 32'd0);
    id_valid = 1'b1; id_use_ra = 1'b1; id_ra = 4'd0;
    step(); idle();
    chk("r0_store", of_a, 32'd0);
    id_valid = 1'b1; id_we_rd = 1'b1; id_rd = 4'd0;
    step(); idle();
    id_valid = 1'b1; id_use_ra = 1'b1; id_ra = 4'd0; id_we_rd = 1'b1; id_rd = 4'd0;
    #1 chk("r0_never_busy", {31'd0, id_stall}, 32'd0);
    step(); idle();

    // Reset while R7 and flags are pending.
    id_valid = 1'b1; id_we_rd = 1'b1; id_rd = 4'd7; id_sets_flags = 1'b1;
    step(); idle();
    id_valid = 1'b1; id_use_ra = 1'b1; id_ra = 4'd7; id_use_flags = 1'b1; id_cond = 4'd0;
    #1 chk("pre_rst_stall", {31'd0, id_stall}, 32'd1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("rst_cycle_valid", {31'd0, of_valid}, 32'd0);
    chk("post_rst_stall", {31'd0, id_stall}, 32'd0);
    step(); idle();
    chk("post_rst_valid", {31'd0, of_valid}, 32'd1);
    chk("post_rst_a", of_a, 32'd0);
    chk("post_rst_cond", {31'd0, of_cond_true}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
